// File: rtl/game_pkg.sv
// Shared game constants and the collision scanner state type.
//
// Positions are packed as {x[18:9], y[8:0]} and refer to the sprite's
// top-left corner. Sprite sizes are 6-bit constants so they can be
// passed directly to the overlap checker.
package game_pkg;

    localparam int POS_W = 19;
    localparam int X_MSB = 18;
    localparam int X_LSB = 9;
    localparam int Y_MSB = 8;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int SIZE_W = 6;
    localparam logic [SIZE_W-1:0] ENEMY_W  = 6'd32;
    localparam logic [SIZE_W-1:0] ENEMY_H  = 6'd24;
    localparam logic [SIZE_W-1:0] PLAYER_W = 6'd20;
    localparam logic [SIZE_W-1:0] PLAYER_H = 6'd24;
    localparam logic [SIZE_W-1:0] BULLET_W = 6'd4;
    localparam logic [SIZE_W-1:0] BULLET_H = 6'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SCAN_P,
        ST_SCAN_E,
        ST_DONE
    } scanState_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned bounding-box overlap test.
//
// Ports:
//   posA, posB       : {x, y} top-left corners of the two boxes
//   widthA, heightA  : size of box A
//   widthB, heightB  : size of box B
//   hit              : 1 when the boxes strictly overlap (touching edges do not count)
module aabb_overlap
    import game_pkg::*;
(
    input  logic [POS_W-1:0]  posA,
    input  logic [POS_W-1:0]  posB,
    input  logic [SIZE_W-1:0] widthA,
    input  logic [SIZE_W-1:0] heightA,
    input  logic [SIZE_W-1:0] widthB,
    input  logic [SIZE_W-1:0] heightB,
    output logic              hit
);

    // Everything is widened to 11 bits so that coordinate + size never wraps.
    logic [10:0] ax, ay, bx, by;
    logic [10:0] aw, ah, bw, bh;

    assign ax = 11'(posA[X_MSB:X_LSB]);
    assign ay = 11'(posA[Y_MSB:0]);
    assign bx = 11'(posB[X_MSB:X_LSB]);
    assign by = 11'(posB[Y_MSB:0]);
    assign aw = 11'(widthA);
    assign ah = 11'(heightA);
    assign bw = 11'(widthB);
    assign bh = 11'(heightB);

    assign hit = (ax < bx + bw) && (bx < ax + aw) &&
                 (ay < by + bh) && (by < ay + ah);

endmodule

// File: rtl/bullet_collision_scanner.sv
// Per-frame bullet collision scanner.
//
// On a frame tick the scanner snapshots all bullet/enemy/player state, then
// walks every player bullet against every enemy (one pair per cycle) and
// then every enemy bullet against the player (one bullet per cycle). The
// resulting kill/clear masks are valid on the o_fDone pulse and hold until
// the next scan starts.
//
// Ports:
//   i_Clk, i_Rst            : clock, synchronous active-high reset
//   i_fTick                 : frame-start pulse requesting a scan
//   i_Enemy*/i_Player*      : enemy and player alive flags and positions
//   i_PlayerBullet*         : player bullet active flags and positions
//   i_EnemyBullet*          : enemy bullet active flags and positions
//   o_EnemyKill             : enemies hit during this scan
//   o_PlayerBulletClear     : player bullets to deactivate
//   o_EnemyBulletClear      : enemy bullets to deactivate
//   o_PlayerHit             : player was hit during this scan
//   o_KillCount             : number of enemies killed
//   o_fBusy, o_fDone        : scan in progress / one-cycle results-valid pulse
//   o_fOverrun              : one-cycle pulse when a tick arrives while busy
module bullet_collision_scanner
    import game_pkg::*;
#(
    parameter int MAX_ENEMY         = 15,
    parameter int MAX_ENEMY_BULLET  = 31,
    parameter int MAX_PLAYER_BULLET = 15
) (
    input  logic                                i_Clk,
    input  logic                                i_Rst,
    input  logic                                i_fTick,
    input  logic [MAX_ENEMY-1:0]                i_EnemyState,
    input  logic [POS_W*MAX_ENEMY-1:0]          i_EnemyPosition,
    input  logic                                i_PlayerState,
    input  logic [POS_W-1:0]                    i_PlayerPosition,
    input  logic [MAX_PLAYER_BULLET-1:0]        i_PlayerBulletState,
    input  logic [POS_W*MAX_PLAYER_BULLET-1:0]  i_PlayerBulletPosition,
    input  logic [MAX_ENEMY_BULLET-1:0]         i_EnemyBulletState,
    input  logic [POS_W*MAX_ENEMY_BULLET-1:0]   i_EnemyBulletPosition,
    output logic [MAX_ENEMY-1:0]                o_EnemyKill,
    output logic [MAX_PLAYER_BULLET-1:0]        o_PlayerBulletClear,
    output logic [MAX_ENEMY_BULLET-1:0]         o_EnemyBulletClear,
    output logic                                o_PlayerHit,
    output logic [3:0]                          o_KillCount,
    output logic                                o_fBusy,
    output logic                                o_fDone,
    output logic                                o_fOverrun
);

    localparam int IW = (MAX_ENEMY > 1)         ? $clog2(MAX_ENEMY)         : 1;
    localparam int JW = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;
    localparam int KW = (MAX_ENEMY_BULLET > 1)  ? $clog2(MAX_ENEMY_BULLET)  : 1;

    localparam logic [IW-1:0]    LAST_I   = IW'(MAX_ENEMY - 1);
    localparam logic [JW-1:0]    LAST_J   = JW'(MAX_PLAYER_BULLET - 1);
    localparam logic [KW-1:0]    LAST_K   = KW'(MAX_ENEMY_BULLET - 1);
    localparam logic [Y_MSB:0]   SCREEN_Y = SCREEN_H[Y_MSB:0];

    scanState_t state, stateNext;

    logic [IW-1:0] enemyIdx;
    logic [JW-1:0] pBulletIdx;
    logic [KW-1:0] eBulletIdx;

    logic [MAX_ENEMY-1:0]                snapEnemyState;
    logic [POS_W*MAX_ENEMY-1:0]          snapEnemyPos;
    logic                                snapPlayerState;
    logic [POS_W-1:0]                    snapPlayerPos;
    logic [MAX_PLAYER_BULLET-1:0]        snapPbState;
    logic [POS_W*MAX_PLAYER_BULLET-1:0]  snapPbPos;
    logic [MAX_ENEMY_BULLET-1:0]         snapEbState;
    logic [POS_W*MAX_ENEMY_BULLET-1:0]   snapEbPos;

    logic [POS_W-1:0] curEnemyPos, curPbPos, curEbPos;
    logic             pbVsEnemyHit, ebVsPlayerHit;

    logic rowDone, doKill, doClearP, doClearE, doHit;

    assign curEnemyPos = snapEnemyPos[enemyIdx*POS_W +: POS_W];
    assign curPbPos    = snapPbPos[pBulletIdx*POS_W +: POS_W];
    assign curEbPos    = snapEbPos[eBulletIdx*POS_W +: POS_W];

    aabb_overlap playerBulletVsEnemy (
        .posA    (curPbPos),
        .posB    (curEnemyPos),
        .widthA  (BULLET_W),
        .heightA (BULLET_H),
        .widthB  (ENEMY_W),
        .heightB (ENEMY_H),
        .hit     (pbVsEnemyHit)
    );

    aabb_overlap enemyBulletVsPlayer (
        .posA    (curEbPos),
        .posB    (snapPlayerPos),
        .widthA  (BULLET_W),
        .heightA (BULLET_H),
        .widthB  (PLAYER_W),
        .heightB (PLAYER_H),
        .hit     (ebVsPlayerHit)
    );

    assign o_fBusy = (state != ST_IDLE);
    assign o_fDone = (state == ST_DONE);

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) state <= ST_IDLE;
        else       state <= stateNext;
    end

    // Next state plus the per-cycle scan actions. A player bullet row ends
    // early when the bullet is inactive, off screen, or has just killed an
    // enemy; an enemy that was already killed this scan cannot be hit again.
    always_comb begin
        stateNext = state;
        rowDone   = 1'b0;
        doKill    = 1'b0;
        doClearP  = 1'b0;
        doClearE  = 1'b0;
        doHit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_fTick) stateNext = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                stateNext = ST_SCAN_P;
            end
            ST_SCAN_P: begin
                if (!snapPbState[pBulletIdx]) begin
                    rowDone = 1'b1;
                end else if (curPbPos[Y_MSB:0] >= SCREEN_Y) begin
                    doClearP = 1'b1;
                    rowDone  = 1'b1;
                end else if (snapEnemyState[enemyIdx] && !o_EnemyKill[enemyIdx] && pbVsEnemyHit) begin
                    doKill   = 1'b1;
                    doClearP = 1'b1;
                    rowDone  = 1'b1;
                end else if (enemyIdx == LAST_I) begin
                    rowDone = 1'b1;
                end
                if (rowDone && (pBulletIdx == LAST_J)) stateNext = ST_SCAN_E;
            end
            ST_SCAN_E: begin
                if (snapEbState[eBulletIdx]) begin
                    if (curEbPos[Y_MSB:0] >= SCREEN_Y) begin
                        doClearE = 1'b1;
                    end else if (snapPlayerState && !o_PlayerHit && ebVsPlayerHit) begin
                        doClearE = 1'b1;
                        doHit    = 1'b1;
                    end
                end
                if (eBulletIdx == LAST_K) stateNext = ST_DONE;
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Snapshot, scan indices and result masks. Results are cleared only when
    // a new scan captures, so they stay stable for the state owners afterwards.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            enemyIdx            <= '0;
            pBulletIdx          <= '0;
            eBulletIdx          <= '0;
            snapEnemyState      <= '0;
            snapEnemyPos        <= '0;
            snapPlayerState     <= 1'b0;
            snapPlayerPos       <= '0;
            snapPbState         <= '0;
            snapPbPos           <= '0;
            snapEbState         <= '0;
            snapEbPos           <= '0;
            o_EnemyKill         <= '0;
            o_PlayerBulletClear <= '0;
            o_EnemyBulletClear  <= '0;
            o_PlayerHit         <= 1'b0;
            o_KillCount         <= '0;
            o_fOverrun          <= 1'b0;
        end else begin
            o_fOverrun <= i_fTick && (state != ST_IDLE);
            case (state)
                ST_CAPTURE: begin
                    snapEnemyState      <= i_EnemyState;
                    snapEnemyPos        <= i_EnemyPosition;
                    snapPlayerState     <= i_PlayerState;
                    snapPlayerPos       <= i_PlayerPosition;
                    snapPbState         <= i_PlayerBulletState;
                    snapPbPos           <= i_PlayerBulletPosition;
                    snapEbState         <= i_EnemyBulletState;
                    snapEbPos           <= i_EnemyBulletPosition;
                    o_EnemyKill         <= '0;
                    o_PlayerBulletClear <= '0;
                    o_EnemyBulletClear  <= '0;
                    o_PlayerHit         <= 1'b0;
                    o_KillCount         <= '0;
                    enemyIdx            <= '0;
                    pBulletIdx          <= '0;
                    eBulletIdx          <= '0;
                end
                ST_SCAN_P: begin
                    if (doKill) begin
                        o_EnemyKill[enemyIdx] <= 1'b1;
                        o_KillCount           <= o_KillCount + 4'd1;
                    end
                    if (doClearP) o_PlayerBulletClear[pBulletIdx] <= 1'b1;
                    if (rowDone) begin
                        enemyIdx   <= '0;
                        pBulletIdx <= pBulletIdx + 1'b1;
                    end else begin
                        enemyIdx <= enemyIdx + 1'b1;
                    end
                end
                ST_SCAN_E: begin
                    if (doClearE) o_EnemyBulletClear[eBulletIdx] <= 1'b1;
                    if (doHit)    o_PlayerHit <= 1'b1;
                    eBulletIdx <= eBulletIdx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Self-checking bench for bullet_collision_scanner: a table of directed
// scans with hand-computed results, randomized scans checked against a
// loop-based reference model, plus overrun and mid-scan reset sequences.
module tb_bullet_collision_scanner;

    localparam int NE  = 15;
    localparam int NEB = 31;
    localparam int NPB = 15;
    localparam int PW  = 19;
    localparam int EW  = 32, EH = 24, PLW = 20, PLH = 24, BW = 4, BH = 8;
    localparam int SCRH = 480;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic [NE-1:0]     enemyState = '0;
    logic [PW*NE-1:0]  enemyPos = '0;
    logic              playerState = 1'b0;
    logic [PW-1:0]     playerPos = '0;
    logic [NPB-1:0]    pbState = '0;
    logic [PW*NPB-1:0] pbPos = '0;
    logic [NEB-1:0]    ebState = '0;
    logic [PW*NEB-1:0] ebPos = '0;
    logic [NE-1:0]     enemyKill;
    logic [NPB-1:0]    pbClear;
    logic [NEB-1:0]    ebClear;
    logic              playerHit;
    logic [3:0]        killCount;
    logic              busy, done, overrun;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    bullet_collision_scanner #(
        .MAX_ENEMY         (NE),
        .MAX_ENEMY_BULLET  (NEB),
        .MAX_PLAYER_BULLET (NPB)
    ) dut (
        .i_Clk                  (clk),
        .i_Rst                  (rst),
        .i_fTick                (tick),
        .i_EnemyState           (enemyState),
        .i_EnemyPosition        (enemyPos),
        .i_PlayerState          (playerState),
        .i_PlayerPosition       (playerPos),
        .i_PlayerBulletState    (pbState),
        .i_PlayerBulletPosition (pbPos),
        .i_EnemyBulletState     (ebState),
        .i_EnemyBulletPosition  (ebPos),
        .o_EnemyKill            (enemyKill),
        .o_PlayerBulletClear    (pbClear),
        .o_EnemyBulletClear     (ebClear),
        .o_PlayerHit            (playerHit),
        .o_KillCount            (killCount),
        .o_fBusy                (busy),
        .o_fDone                (done),
        .o_fOverrun             (overrun)
    );

    typedef struct {
        string             name;
        logic [NE-1:0]     enemyState;
        logic [PW*NE-1:0]  enemyPos;
        logic              playerState;
        logic [PW-1:0]     playerPos;
        logic [NPB-1:0]    pbState;
        logic [PW*NPB-1:0] pbPos;
        logic [NEB-1:0]    ebState;
        logic [PW*NEB-1:0] ebPos;
        logic [NE-1:0]     expKill;
        logic [NPB-1:0]    expPbClear;
        logic [NEB-1:0]    expEbClear;
        logic              expHit;
        logic [3:0]        expCount;
        int                expLatency;
    } vector_t;

    vector_t vecs[6];

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [PW-1:0] pos(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {xv[9:0], yv[8:0]};
    endfunction

    function automatic vector_t blankVector(input string name);
        vector_t v;
        v.name = name;
        v.enemyState = '0;  v.enemyPos = '0;
        v.playerState = 1'b0; v.playerPos = '0;
        v.pbState = '0;     v.pbPos = '0;
        v.ebState = '0;     v.ebPos = '0;
        v.expKill = '0;     v.expPbClear = '0; v.expEbClear = '0;
        v.expHit = 1'b0;    v.expCount = '0;  v.expLatency = 0;
        return v;
    endfunction

    function automatic bit boxesOverlap(input int ax, input int ay, input int aw, input int ah,
                                        input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    // Reference model: walks the scan rules in plain integer arithmetic and
    // also tallies how many scan cycles the player-bullet phase costs.
    function automatic vector_t modelScan(input vector_t v);
        vector_t r = v;
        int pCycles = 0;
        int kills = 0;
        r.expKill = '0; r.expPbClear = '0; r.expEbClear = '0; r.expHit = 1'b0;
        for (int j = 0; j < NPB; j++) begin
            int bx = v.pbPos[j*PW+9 +: 10];
            int by = v.pbPos[j*PW +: 9];
            if (!v.pbState[j]) begin
                pCycles++;
            end else if (by >= SCRH) begin
                r.expPbClear[j] = 1'b1;
                pCycles++;
            end else begin
                for (int i = 0; i < NE; i++) begin
                    int ex = v.enemyPos[i*PW+9 +: 10];
                    int ey = v.enemyPos[i*PW +: 9];
                    pCycles++;
                    if (v.enemyState[i] && !r.expKill[i] && boxesOverlap(bx, by, BW, BH, ex, ey, EW, EH)) begin
                        r.expKill[i] = 1'b1;
                        r.expPbClear[j] = 1'b1;
                        kills++;
                        break;
                    end
                end
            end
        end
        for (int k = 0; k < NEB; k++) begin
            int bx = v.ebPos[k*PW+9 +: 10];
            int by = v.ebPos[k*PW +: 9];
            int px = v.playerPos[18:9];
            int py = v.playerPos[8:0];
            if (v.ebState[k]) begin
                if (by >= SCRH) begin
                    r.expEbClear[k] = 1'b1;
                end else if (v.playerState && !r.expHit && boxesOverlap(bx, by, BW, BH, px, py, PLW, PLH)) begin
                    r.expEbClear[k] = 1'b1;
                    r.expHit = 1'b1;
                end
            end
        end
        r.expCount = 4'(kills);
        // Edges counted inclusively from the tick-sampling edge to the edge
        // raising o_fDone: tick/capture/enter-scan, scan phases, done.
        r.expLatency = pCycles + NEB + 2;
        return r;
    endfunction

    task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        enemyState  = v.enemyState;
        enemyPos    = v.enemyPos;
        playerState = v.playerState;
        playerPos   = v.playerPos;
        pbState     = v.pbState;
        pbPos       = v.pbPos;
        ebState     = v.ebState;
        ebPos       = v.ebPos;
    endtask

    // Called at a falling edge; returns at the falling edge where o_fDone is seen.
    task automatic runScan(output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        tick = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            tick = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkScan(input vector_t v, input int lat, input bit ok);
        checkOutput({v.name, " done seen"}, 64'(ok), 64'd1);
        checkOutput({v.name, " latency"}, 64'(lat), 64'(v.expLatency));
        checkOutput({v.name, " enemy kill"}, 64'(enemyKill), 64'(v.expKill));
        checkOutput({v.name, " player bullet clear"}, 64'(pbClear), 64'(v.expPbClear));
        checkOutput({v.name, " enemy bullet clear"}, 64'(ebClear), 64'(v.expEbClear));
        checkOutput({v.name, " player hit"}, 64'(playerHit), 64'(v.expHit));
        checkOutput({v.name, " kill count"}, 64'(killCount), 64'(v.expCount));
        checkOutput({v.name, " busy in done"}, 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput({v.name, " idle after done"}, 64'({busy, done}), 64'd0);
        checkOutput({v.name, " kill held"}, 64'(enemyKill), 64'(v.expKill));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " enemy kill"}, 64'(enemyKill), 64'd0);
        checkOutput({tag, " player bullet clear"}, 64'(pbClear), 64'd0);
        checkOutput({tag, " enemy bullet clear"}, 64'(ebClear), 64'd0);
        checkOutput({tag, " player hit"}, 64'(playerHit), 64'd0);
        checkOutput({tag, " kill count"}, 64'(killCount), 64'd0);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd0);
        checkOutput({tag, " overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        vector_t v;
        int lat;
        bit ok;
        int ovCount;
        int doneCount;

        // Directed vectors with hand-computed results.
        vecs[0] = blankVector("single kill");
        vecs[0].enemyState[0] = 1'b1;
        vecs[0].enemyPos[0*PW +: PW] = pos(100, 50);
        vecs[0].pbState[0] = 1'b1;
        vecs[0].pbPos[0*PW +: PW] = pos(110, 60);
        vecs[0].expKill = 15'h1; vecs[0].expPbClear = 15'h1; vecs[0].expCount = 4'd1;
        vecs[0].expLatency = 48;

        vecs[1] = blankVector("right edge touch");
        vecs[1].enemyState[0] = 1'b1;
        vecs[1].enemyPos[0*PW +: PW] = pos(100, 50);
        vecs[1].pbState[0] = 1'b1;
        vecs[1].pbPos[0*PW +: PW] = pos(132, 60);
        vecs[1].expLatency = 62;

        vecs[2] = blankVector("two bullets one enemy");
        vecs[2].enemyState[3] = 1'b1;
        vecs[2].enemyPos[3*PW +: PW] = pos(200, 100);
        vecs[2].enemyState[5] = 1'b1;
        vecs[2].enemyPos[5*PW +: PW] = pos(400, 100);
        vecs[2].pbState[1:0] = 2'b11;
        vecs[2].pbPos[0*PW +: PW] = pos(210, 110);
        vecs[2].pbPos[1*PW +: PW] = pos(220, 110);
        vecs[2].expKill = 15'h8; vecs[2].expPbClear = 15'h1; vecs[2].expCount = 4'd1;
        vecs[2].expLatency = 65;

        vecs[3] = blankVector("dead player");
        vecs[3].playerPos = pos(300, 400);
        vecs[3].ebState[2] = 1'b1;
        vecs[3].ebPos[2*PW +: PW] = pos(305, 405);
        vecs[3].ebState[4] = 1'b1;
        vecs[3].ebPos[4*PW +: PW] = pos(50, 480);
        vecs[3].expEbClear = 31'h10;
        vecs[3].expLatency = 48;

        vecs[4] = blankVector("first hit only");
        vecs[4].playerState = 1'b1;
        vecs[4].playerPos = pos(300, 400);
        vecs[4].ebState[0] = 1'b1;
        vecs[4].ebPos[0*PW +: PW] = pos(320, 405);
        vecs[4].ebState[1] = 1'b1;
        vecs[4].ebPos[1*PW +: PW] = pos(305, 405);
        vecs[4].ebState[3] = 1'b1;
        vecs[4].ebPos[3*PW +: PW] = pos(296, 405);
        vecs[4].ebState[6] = 1'b1;
        vecs[4].ebPos[6*PW +: PW] = pos(310, 410);
        vecs[4].expEbClear = 31'h2; vecs[4].expHit = 1'b1;
        vecs[4].expLatency = 48;

        vecs[5] = blankVector("edges and wrap");
        vecs[5].enemyState[0] = 1'b1;
        vecs[5].enemyPos[0*PW +: PW] = pos(100, 50);
        vecs[5].pbState[3:0] = 4'hF;
        vecs[5].pbPos[0*PW +: PW] = pos(100, 74);
        vecs[5].pbPos[1*PW +: PW] = pos(100, 73);
        vecs[5].pbPos[2*PW +: PW] = pos(100, 500);
        vecs[5].pbPos[3*PW +: PW] = pos(96, 60);
        vecs[5].expKill = 15'h1; vecs[5].expPbClear = 15'h6; vecs[5].expCount = 4'd1;
        vecs[5].expLatency = 76;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            applyStimulus(vecs[n]);
            runScan(lat, ok);
            checkScan(vecs[n], lat, ok);
        end

        // Randomized scans against the reference model.
        for (int n = 0; n < 12; n++) begin
            v = blankVector($sformatf("random %0d", n));
            v.enemyState = NE'($urandom);
            for (int i = 0; i < NE; i++)
                v.enemyPos[i*PW +: PW] = pos(80 + $urandom_range(0, 200), 40 + $urandom_range(0, 120));
            v.pbState = NPB'($urandom);
            for (int j = 0; j < NPB; j++)
                v.pbPos[j*PW +: PW] = pos(80 + $urandom_range(0, 240),
                                          ($urandom_range(0, 7) == 0) ? 470 + $urandom_range(0, 41)
                                                                     : 30 + $urandom_range(0, 180));
            v.playerState = ($urandom_range(0, 3) != 0);
            v.playerPos = pos(280 + $urandom_range(0, 40), 380 + $urandom_range(0, 60));
            v.ebState = NEB'($urandom);
            for (int k = 0; k < NEB; k++)
                v.ebPos[k*PW +: PW] = pos(270 + $urandom_range(0, 60), 370 + $urandom_range(0, 120));
            v = modelScan(v);
            applyStimulus(v);
            runScan(lat, ok);
            checkScan(v, lat, ok);
        end

        // Overrun: a second tick 10 cycles into a scan, then a tick in the DONE cycle.
        applyStimulus(vecs[2]);
        ovCount = 0;
        lat = 0;
        ok = 1'b0;
        tick = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            tick = (lat == 10);
            if (overrun) ovCount++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("overrun mid-scan pulses", 64'(ovCount), 64'd1);
        checkOutput("overrun scan latency", 64'(lat), 64'(vecs[2].expLatency));
        checkOutput("overrun scan done", 64'(ok), 64'd1);
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        checkOutput("overrun done-cycle pulse", 64'(overrun), 64'd1);
        checkOutput("done-cycle tick ignored", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("overrun single cycle", 64'(overrun), 64'd0);
        checkOutput("still idle", 64'(busy), 64'd0);

        // Reset at cycle 50 of a long scan: outputs clear, no done follows.
        v = blankVector("reset scan");
        v.enemyState[0] = 1'b1;
        v.enemyPos[0*PW +: PW] = pos(100, 50);
        v.pbState = '1;
        v.pbPos[0*PW +: PW] = pos(110, 60);
        for (int j = 1; j < NPB; j++) v.pbPos[j*PW +: PW] = pos(600, 300);
        applyStimulus(v);
        tick = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            tick = 1'b0;
        end
        checkOutput("pre-reset kill", 64'(enemyKill), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("mid-scan reset");
        doneCount = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("no done after reset", 64'(doneCount), 64'd0);

        // The scanner recovers normally after the abort.
        applyStimulus(vecs[0]);
        runScan(lat, ok);
        checkScan(vecs[0], lat, ok);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
